// File: rtl/seg_scan_decoder.sv
// Seven-segment scan decoder: filters and decodes a sampled segment/digit bus back to BCD per digit.
// Optional saturating invalid-pattern counter enabled by SEG_SCAN_DECODER_ERR_COUNT_EN.
module seg_scan_decoder #(
   parameter int                    NUM_DIGITS    = 8,
   parameter int                    STABLE_CYCLES = 4,
   parameter logic [NUM_DIGITS-1:0] DIGIT_MASK    = {NUM_DIGITS{1'b1}}
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              seg_in,
   input  logic [NUM_DIGITS-1:0]   dig_in,
   output logic [4*NUM_DIGITS-1:0] digit_out,
   output logic [NUM_DIGITS-1:0]   dp_out,
   output logic [NUM_DIGITS-1:0]   err_out,
   output logic                    frame_valid,
   output logic [7:0]              err_count
);

   localparam int         IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [7:0] STAB_SAT = 8'(STABLE_CYCLES);
   localparam logic [7:0] STAB_PRE = 8'(STABLE_CYCLES - 2);

   logic [7:0]            s_seg;
   logic [7:0]            p_seg;
   logic [NUM_DIGITS-1:0] s_dig;
   logic [NUM_DIGITS-1:0] p_dig;
   logic [7:0]            stab;
   logic [NUM_DIGITS-1:0] seen;

   logic                  same;
   logic                  dig_sel;
   logic                  capture;
   logic [IDX_W-1:0]      cap_idx;
   logic [3:0]            dec_val;
   logic                  dec_err;
   logic [NUM_DIGITS-1:0] new_seen;
   logic                  frame_hit;

   // Returns {invalid, bcd}; anything outside the ten digit glyphs is invalid.
   function automatic logic [4:0] decode7(input logic [6:0] pat);
      logic [4:0] r;
      case (pat)
         7'h3F:   r = {1'b0, 4'd0};
         7'h06:   r = {1'b0, 4'd1};
         7'h5B:   r = {1'b0, 4'd2};
         7'h4F:   r = {1'b0, 4'd3};
         7'h66:   r = {1'b0, 4'd4};
         7'h6D:   r = {1'b0, 4'd5};
         7'h7D:   r = {1'b0, 4'd6};
         7'h07:   r = {1'b0, 4'd7};
         7'h7F:   r = {1'b0, 4'd8};
         7'h67:   r = {1'b0, 4'd9};
         default: r = {1'b1, 4'hF};
      endcase
      return r;
   endfunction

   always_comb begin
      same    = (s_seg == p_seg) && (s_dig == p_dig);
      dig_sel = $onehot(~s_dig);
      // stab moving from STABLE_CYCLES-2 to STABLE_CYCLES-1 is the single capture cycle.
      capture = same && (stab == STAB_PRE) && dig_sel;
      cap_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!s_dig[i]) cap_idx = IDX_W'(i);
      end
      {dec_err, dec_val} = decode7(s_seg[6:0]);
      new_seen  = seen | ~s_dig;
      frame_hit = ((new_seen & DIGIT_MASK) == DIGIT_MASK);
   end

   // frame_valid is a one-cycle strobe with no back-pressure: it rises on the
   // capture that completes DIGIT_MASK and the consumer must take it then.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_seg       <= '0;
         p_seg       <= '0;
         s_dig       <= '0;
         p_dig       <= '0;
         stab        <= '0;
         seen        <= '0;
         digit_out   <= '0;
         dp_out      <= '0;
         err_out     <= '0;
         frame_valid <= 1'b0;
      end else begin
         s_seg <= seg_in;
         s_dig <= dig_in;
         p_seg <= s_seg;
         p_dig <= s_dig;

         if (!same) begin
            stab <= '0;
         end else if (stab < STAB_SAT) begin
            stab <= stab + 8'd1;
         end

         frame_valid <= 1'b0;
         if (capture) begin
            digit_out[4*cap_idx +: 4] <= dec_val;
            err_out[cap_idx]          <= dec_err;
            dp_out[cap_idx]           <= s_seg[7];
            // The completing digit starts no credit toward the next frame.
            if (frame_hit) begin
               frame_valid <= 1'b1;
               seen        <= '0;
            end else begin
               seen <= new_seen & DIGIT_MASK;
            end
         end
      end
   end

`ifdef SEG_SCAN_DECODER_ERR_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= 8'h00;
      end else if (capture && dec_err && (err_count != 8'hFF)) begin
         err_count <= err_count + 8'd1;
      end
   end
`else
   assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: two instances (static mask 8'h01, full mask 8'hFF) share one input bus.
module tb_seg_scan_decoder;

   localparam int W = 65;  // {cycle[15:0], frame, err[7:0], dp[7:0], digit[31:0]}

`ifdef SEG_SCAN_DECODER_ERR_COUNT_EN
   localparam logic [7:0] ERR_AFTER_INVALID = 8'd1;
`else
   localparam logic [7:0] ERR_AFTER_INVALID = 8'd0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  seg_in = 8'h00;
   logic [7:0]  dig_in = 8'hFF;

   logic [31:0] dig_s, dig_m;
   logic [7:0]  dp_s, dp_m, err_s, err_m, cnt_s, cnt_m;
   logic        fv_s, fv_m;

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];
   logic [47:0]  prev0, prev1;
   logic         pfv0 = 1'b0;
   logic         pfv1 = 1'b0;

   seg_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(4), .DIGIT_MASK(8'h01)) dut_s (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dig_in(dig_in),
      .digit_out(dig_s), .dp_out(dp_s), .err_out(err_s),
      .frame_valid(fv_s), .err_count(cnt_s)
   );

   seg_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(4), .DIGIT_MASK(8'hFF)) dut_m (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dig_in(dig_in),
      .digit_out(dig_m), .dp_out(dp_m), .err_out(err_m),
      .frame_valid(fv_m), .err_count(cnt_m)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic push(input int d, input logic [31:0] dg, input logic [7:0] dp,
                       input logic [7:0] er, input logic fr, input int at);
      logic [W-1:0] e;
      e = {16'(at), fr, er, dp, dg};
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   task automatic push_both(input logic [31:0] dg, input logic [7:0] dp, input logic [7:0] er,
                            input logic fr_s, input logic fr_m, input int at);
      push(0, dg, dp, er, fr_s, at);
      push(1, dg, dp, er, fr_m, at);
   endtask

   // driver: called at a negedge, holds the inputs for n cycles
   task automatic apply(input logic [7:0] seg, input logic [7:0] dig, input int n);
      seg_in = seg;
      dig_in = dig;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_event(input int d, input logic [W-1:0] act);
      logic [W-1:0] e;
      int n;
      checks++;
      n = (d == 0) ? exp_q0.size() : exp_q1.size();
      if (n == 0) begin
         failures++;
         $display("FAIL unexpected_event dut%0d actual=%h expected=none", d, act);
      end else begin
         e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         if (act !== e) begin
            failures++;
            $display("FAIL event dut%0d actual(cyc,fv,err,dp,dig)=%h expected=%h", d, act, e);
         end
      end
   endtask

   // monitor: an event is any output change or a frame_valid pulse
   always @(negedge clk) begin
      logic [W-1:0] a0, a1;
      a0 = {16'(cyc), fv_s, err_s, dp_s, dig_s};
      a1 = {16'(cyc), fv_m, err_m, dp_m, dig_m};
      if (mon_en) begin
         if (fv_s || (a0[47:0] != prev0)) check_event(0, a0);
         if (fv_m || (a1[47:0] != prev1)) check_event(1, a1);
         if (fv_s) begin
            checks++;
            if (pfv0) begin failures++; $display("FAIL fv_back_to_back dut0 actual=1 expected=0"); end
         end
         if (fv_m) begin
            checks++;
            if (pfv1) begin failures++; $display("FAIL fv_back_to_back dut1 actual=1 expected=0"); end
         end
      end
      prev0 = a0[47:0];
      prev1 = a1[47:0];
      pfv0  = fv_s;
      pfv1  = fv_m;
   end

   logic [7:0]  codes_a[8] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
   logic [31:0] t3_exp[8]  = '{32'h00000000, 32'h00000010, 32'h00000210, 32'h00003210,
                               32'h00043210, 32'h00543210, 32'h06543210, 32'h76543210};
   logic [7:0]  codes_b[4] = '{8'h67, 8'h7F, 8'h07, 8'h7D};
   logic [31:0] t6a_exp[4] = '{32'h76543919, 32'h76543989, 32'h76543789, 32'h76546789};
   logic [7:0]  codes_c[4] = '{8'h66, 8'h6D, 8'h7D, 8'h07};
   logic [31:0] t6b_exp[4] = '{32'h00040000, 32'h00540000, 32'h06540000, 32'h76540000};

   initial begin
      logic [7:0] dsel;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_digit_s", 64'(dig_s), 64'h0);
      check("rst_digit_m", 64'(dig_m), 64'h0);
      check("rst_dp_err_s", 64'({dp_s, err_s}), 64'h0);
      check("rst_dp_err_m", 64'({dp_m, err_m}), 64'h0);
      check("rst_fv", 64'({fv_s, fv_m}), 64'h0);
      check("rst_err_count", 64'({cnt_s, cnt_m}), 64'h0);
      mon_en = 1'b1;

      // static digit capture: digit 0 shows 2
      push_both(32'h00000002, 8'h00, 8'h00, 1'b1, 1'b0, cyc + 5);
      apply(8'h5B, 8'hFE, 8);

      // glitch: 1 held only 3 samples, then 3 steady
      apply(8'h06, 8'hFE, 3);
      push_both(32'h00000003, 8'h00, 8'h00, 1'b1, 1'b0, cyc + 5);
      apply(8'h4F, 8'hFE, 8);

      // multiplexed frame over all eight digits
      for (int i = 0; i < 8; i++) begin
         dsel = 8'hFF;
         dsel[i] = 1'b0;
         push_both(t3_exp[i], 8'h00, 8'h00, i == 0, i == 7, cyc + 5);
         apply(codes_a[i], dsel, 6);
      end

      // invalid pattern with dp on digit 2, then a valid 9
      push_both(32'h76543F10, 8'h04, 8'h04, 1'b0, 1'b0, cyc + 5);
      apply(8'hEF, 8'hFB, 8);
      check("err_count_s_invalid", 64'(cnt_s), 64'(ERR_AFTER_INVALID));
      check("err_count_m_invalid", 64'(cnt_m), 64'(ERR_AFTER_INVALID));
      push_both(32'h76543910, 8'h00, 8'h00, 1'b0, 1'b0, cyc + 5);
      apply(8'h67, 8'hFB, 8);

      // blanked and multi-select: no captures at all
      apply(8'h3F, 8'hFF, 10);
      apply(8'h3F, 8'hFC, 10);
      check("err_count_s_blank", 64'(cnt_s), 64'(ERR_AFTER_INVALID));
      check("digit_m_blank", 64'(dig_m), 64'h76543910);

      // partial frame on digits 0..3, reset, then digits 4..7
      for (int i = 0; i < 4; i++) begin
         dsel = 8'hFF;
         dsel[i] = 1'b0;
         push_both(t6a_exp[i], 8'h00, 8'h00, i == 0, 1'b0, cyc + 5);
         apply(codes_b[i], dsel, 6);
      end
      push_both(32'h0, 8'h00, 8'h00, 1'b0, 1'b0, cyc + 1);
      rst    = 1'b1;
      seg_in = 8'h00;
      dig_in = 8'hFF;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_digit", 64'({dig_s, dig_m}), 64'h0);
      check("mid_rst_dp_err", 64'({dp_s, err_s, dp_m, err_m}), 64'h0);
      check("mid_rst_err_count", 64'({cnt_s, cnt_m}), 64'h0);
      for (int i = 0; i < 4; i++) begin
         dsel = 8'hFF;
         dsel[i+4] = 1'b0;
         push_both(t6b_exp[i], 8'h00, 8'h00, 1'b0, 1'b0, cyc + 5);
         apply(codes_c[i], dsel, 6);
      end
      apply(8'h00, 8'hFF, 10);

      check("final_digit_m", 64'(dig_m), 64'h76540000);
      check("final_err_count", 64'({cnt_s, cnt_m}), 64'h0);
      check("pending_events_dut0", 64'(exp_q0.size()), 64'h0);
      check("pending_events_dut1", 64'(exp_q1.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
